asoc_frame_packer: RTL and testbench

//  Downstream neighbour of the ASOC readout capture stage. Takes deserialized 12-bit ASOC samples
//  (valid/ready, channel-tagged, window-terminated by s_last) and packs one trigger's window into a

---
 rtl/asoc_frame_packer_if.sv | 22 ++
 rtl/asoc_frame_packer.sv | 186 ++++++++++++++++++
 tb/tb_asoc_frame_packer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asoc_frame_packer_if.sv
// rtl/asoc_frame_packer_if.sv - sample input and framed word output handshake bundle
interface asoc_frame_packer_if;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_chan;
  logic [11:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (
    input  s_valid, s_chan, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_chan, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/asoc_frame_packer.sv
// rtl/asoc_frame_packer.sv - packs one trigger window of 12-bit ASOC samples into a framed 32-bit stream
module asoc_frame_packer #(
  parameter int SAMPLE_W  = 12,
  parameter int MAX_WORDS = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trig_in,
  input  logic [31:0]          ts_in,
  asoc_frame_packer_if.master  bus,
  output logic                 busy,
  output logic                 trig_drop,
  output logic [15:0]          drop_cnt
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, TRAIL} state_t;
  localparam logic [9:0] MAX_W = 10'(MAX_WORDS);

  state_t                state, state_nx;
  logic [31:0]           ts_q;
  logic [15:0]           evt_cnt;
  logic                  held;
  logic [1:0]            held_chan;
  logic [SAMPLE_W-1:0]   held_data;
  logic [9:0]            wcnt;
  logic [15:0]           csum;
  logic                  trunc;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic [31:0]           m_data_q;

  logic                  out_free;
  logic                  full;
  logic                  chan_diff;
  logic                  accept;
  logic                  s_ready_c;
  logic                  load;
  logic                  load_last;
  logic                  load_sum;
  logic                  load_data;
  logic                  hold_set;
  logic                  hold_clr;
  logic [31:0]           load_word;

  function automatic logic [31:0] data_word(input logic [1:0] c, input logic p,
                                            input logic [11:0] a, input logic [11:0] b);
    return {2'b01, c, p, 3'b000, a, b};
  endfunction

  assign out_free    = !m_valid_q || bus.m_ready;
  assign full        = (wcnt == MAX_W);
  assign chan_diff   = held && (bus.s_chan != held_chan);
  assign accept      = bus.s_valid && s_ready_c;
  assign busy        = (state != IDLE);
  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trig_in)                state_nx = HDR0;
      HDR0:    if (out_free)               state_nx = HDR1;
      HDR1:    if (out_free)               state_nx = DATA;
      DATA:    if (accept && bus.s_last)   state_nx = TRAIL;
      TRAIL:   if (out_free)               state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready_c = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    load_sum  = 1'b0;
    load_data = 1'b0;
    hold_set  = 1'b0;
    hold_clr  = 1'b0;
    load_word = 32'h0;
    case (state)
      HDR0: if (out_free) begin
        load      = 1'b1;
        load_sum  = 1'b1;
        load_word = {2'b10, 14'h0, evt_cnt};
      end
      HDR1: if (out_free) begin
        load      = 1'b1;
        load_sum  = 1'b1;
        load_word = ts_q;
      end
      DATA: begin
        if (full) begin
          // Frame is full: swallow the rest of the window regardless of downstream.
          s_ready_c = 1'b1;
        end else begin
          s_ready_c = out_free && !chan_diff;
          if (out_free && bus.s_valid && chan_diff) begin
            load      = 1'b1;
            load_sum  = 1'b1;
            load_data = 1'b1;
            hold_clr  = 1'b1;
            load_word = data_word(held_chan, 1'b0, held_data, 12'h0);
          end else if (bus.s_valid && s_ready_c) begin
            if (held) begin
              load      = 1'b1;
              load_sum  = 1'b1;
              load_data = 1'b1;
              hold_clr  = 1'b1;
              load_word = data_word(held_chan, 1'b1, held_data, bus.s_data);
            end else if (bus.s_last) begin
              load      = 1'b1;
              load_sum  = 1'b1;
              load_data = 1'b1;
              load_word = data_word(bus.s_chan, 1'b0, bus.s_data, 12'h0);
            end else begin
              hold_set  = 1'b1;
            end
          end
        end
      end
      TRAIL: if (out_free) begin
        load      = 1'b1;
        load_last = 1'b1;
        load_word = {2'b11, trunc, 3'b000, wcnt, csum};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= 32'h0;
      evt_cnt   <= 16'h0;
      held      <= 1'b0;
      held_chan <= 2'b00;
      held_data <= '0;
      wcnt      <= 10'h0;
      csum      <= 16'h0;
      trunc     <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= 32'h0;
      trig_drop <= 1'b0;
      drop_cnt  <= 16'h0;
    end else begin
      trig_drop <= trig_in && (state != IDLE);
      if (trig_in && (state != IDLE) && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      if (state == IDLE && trig_in) begin
        ts_q  <= ts_in;
        wcnt  <= 10'h0;
        csum  <= 16'h0;
        trunc <= 1'b0;
        held  <= 1'b0;
      end
      if (load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= load_word;
        m_last_q  <= load_last;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
      if (load_sum)
        csum <= csum ^ load_word[31:16] ^ load_word[15:0];
      if (load_data)
        wcnt <= wcnt + 10'd1;
      if (hold_set) begin
        held      <= 1'b1;
        held_chan <= bus.s_chan;
        held_data <= bus.s_data;
      end
      if (hold_clr)
        held <= 1'b0;
      if (state == DATA && full && accept)
        trunc <= 1'b1;
      if (state == TRAIL && out_free)
        evt_cnt <= evt_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_asoc_frame_packer.sv
// tb/tb_asoc_frame_packer.sv - scoreboard bench for asoc_frame_packer
module tb_asoc_frame_packer;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig_in = 1'b0;
  logic [31:0] ts_in = 32'h0;
  logic        busy;
  logic        trig_drop;
  logic [15:0] drop_cnt;

  asoc_frame_packer_if bus();

  asoc_frame_packer #(.SAMPLE_W(12), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_in   (trig_in),
    .ts_in     (ts_in),
    .bus       (bus),
    .busy      (busy),
    .trig_drop (trig_drop),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          bp_mode  = 0;
  int          drop_pulses = 0;
  int          evt_model = 0;
  int          n_acc;
  bit          drv_timeout;
  logic [15:0] mdl_cs;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [1:0]  f_chan[$];
  logic [11:0] f_data[$];
  int          stall_q[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word;
  logic [32:0] exp_w;
  logic [32:0] got_w;

  // Output monitor: drives m_ready, checks stall stability and pops the scoreboard.
  always begin
    @(negedge clk);
    case (bp_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = ($urandom_range(0, 9) < 6);
      default: bus.m_ready = 1'b0;
    endcase
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      got_w = {bus.m_last, bus.m_data};
      if (prev_stall) begin
        n_checks++;
        if (bus.m_valid !== 1'b1 || got_w !== prev_word) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b word=%h, required valid=1 word=%h", bus.m_valid, got_w, prev_word);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        obs_q.push_back(got_w);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got %h, required no word", got_w);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL scoreboard_word: got %h, required %h", got_w, exp_w);
          end
        end
      end
      if (trig_drop === 1'b1) drop_pulses++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_word  = got_w;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] w, input logic l, input logic sum);
    exp_q.push_back({l, w});
    if (sum) mdl_cs = mdl_cs ^ w[31:16] ^ w[15:0];
  endtask

  // Reference framing of the current f_chan/f_data window.
  task automatic model_frame(input logic [31:0] ts);
    logic [9:0]  wc = 10'd0;
    logic        tr = 1'b0;
    logic        hv = 1'b0;
    logic [1:0]  hc = 2'b00;
    logic [11:0] hd = 12'h0;
    logic [15:0] ev;
    logic        l;
    ev = 16'(evt_model);
    mdl_cs = 16'h0;
    push_exp({2'b10, 14'h0, ev}, 1'b0, 1'b1);
    push_exp(ts, 1'b0, 1'b1);
    for (int i = 0; i < f_chan.size(); i++) begin
      l = (i == f_chan.size() - 1);
      if (hv && f_chan[i] != hc) begin
        push_exp({2'b01, hc, 1'b0, 3'b000, hd, 12'h000}, 1'b0, 1'b1);
        wc++;
        hv = 1'b0;
      end
      if (wc >= 10'(MAXW)) begin
        tr = 1'b1;
      end else if (hv) begin
        push_exp({2'b01, hc, 1'b1, 3'b000, hd, f_data[i]}, 1'b0, 1'b1);
        wc++;
        hv = 1'b0;
      end else if (l) begin
        push_exp({2'b01, f_chan[i], 1'b0, 3'b000, f_data[i], 12'h000}, 1'b0, 1'b1);
        wc++;
      end else begin
        hv = 1'b1;
        hc = f_chan[i];
        hd = f_data[i];
      end
    end
    push_exp({2'b11, tr, 3'b000, wc, mdl_cs}, 1'b1, 1'b0);
    evt_model = (evt_model + 1) & 16'hFFFF;
  endtask

  task automatic send_frame(input logic [31:0] ts);
    int w;
    model_frame(ts);
    stall_q.delete();
    n_acc = 0;
    drv_timeout = 1'b0;
    @(negedge clk);
    trig_in = 1'b1;
    ts_in   = ts;
    @(negedge clk);
    trig_in = 1'b0;
    for (int i = 0; i < f_chan.size(); i++) begin
      bus.s_valid = 1'b1;
      bus.s_chan  = f_chan[i];
      bus.s_data  = f_data[i];
      bus.s_last  = (i == f_chan.size() - 1);
      #3;
      w = 0;
      while (!bus.s_ready && w < 2000) begin
        @(negedge clk);
        #3;
        w++;
      end
      if (w >= 2000) begin
        drv_timeout = 1'b1;
        break;
      end
      stall_q.push_back(w);
      n_acc++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    @(negedge clk);
    ok = (c < 5000);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.s_valid = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    n_checks++;
    if ({bus.m_valid, bus.m_last, bus.m_data, busy, trig_drop, drop_cnt, bus.s_ready} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h busy=%b drop=%b cnt=%h rdy=%b, required all 0",
               bus.m_valid, bus.m_last, bus.m_data, busy, trig_drop, drop_cnt, bus.s_ready);
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    n_checks++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%b busy=%b rdy=%b, required 0 0 0", bus.m_valid, busy, bus.s_ready);
    end
  endtask

  task automatic test_basic;
    bit ok;
    bp_mode = 0;
    obs_q.delete();
    f_chan = '{2'd1, 2'd1, 2'd1, 2'd1};
    f_data = '{12'h111, 12'h222, 12'h333, 12'h444};
    send_frame(32'h1234_5678);
    drain(ok);
    n_checks++;
    if (!ok || drv_timeout || obs_q.size() != 5) begin
      n_fail++;
      $display("FAIL basic_words: got %0d words ok=%b, required 5 words", obs_q.size(), ok);
    end else begin
      n_checks++;
      if (obs_q[0] !== 33'h0_8000_0000 || obs_q[1] !== 33'h0_1234_5678) begin
        n_fail++;
        $display("FAIL basic_headers: got %h %h, required 080000000 012345678", obs_q[0], obs_q[1]);
      end
      n_checks++;
      if (obs_q[2] !== 33'h0_5811_1222 || obs_q[3] !== 33'h0_5833_3444) begin
        n_fail++;
        $display("FAIL basic_data: got %h %h, required 058111222 058333444", obs_q[2], obs_q[3]);
      end
      n_checks++;
      if (obs_q[4] !== 33'h1_C002_E208) begin
        n_fail++;
        $display("FAIL basic_trailer: got %h, required 1c002e208", obs_q[4]);
      end
    end
  endtask

  task automatic test_single_tail;
    bit ok;
    logic [32:0] w;
    obs_q.delete();
    f_chan = '{2'd0, 2'd0, 2'd0};
    f_data = '{12'h0A1, 12'h0B2, 12'h0C3};
    send_frame(32'hCAFE_0001);
    drain(ok);
    n_checks++;
    if (!ok || drv_timeout || obs_q.size() != 5) begin
      n_fail++;
      $display("FAIL tail_words: got %0d words ok=%b, required 5 words", obs_q.size(), ok);
    end else begin
      w = obs_q[0];
      n_checks++;
      if (w[15:0] !== 16'd1) begin
        n_fail++;
        $display("FAIL tail_evt_cnt: got %h, required 0001", w[15:0]);
      end
      w = obs_q[3];
      n_checks++;
      if (w !== 33'h0_400C_3000) begin
        n_fail++;
        $display("FAIL tail_single: got %h, required 0400c3000", w);
      end
      w = obs_q[4];
      n_checks++;
      if (w[25:16] !== 10'd2 || w[29] !== 1'b0) begin
        n_fail++;
        $display("FAIL tail_wcnt: got wcnt=%0d trunc=%b, required 2 0", w[25:16], w[29]);
      end
    end
  endtask

  task automatic test_flush;
    bit ok;
    obs_q.delete();
    f_chan = '{2'd2, 2'd3, 2'd3};
    f_data = '{12'hAAA, 12'hBBB, 12'hCCC};
    send_frame(32'h0000_0042);
    drain(ok);
    n_checks++;
    if (!ok || drv_timeout || obs_q.size() != 5 || stall_q.size() != 3) begin
      n_fail++;
      $display("FAIL flush_words: got %0d words ok=%b, required 5 words", obs_q.size(), ok);
    end else begin
      n_checks++;
      if (obs_q[2] !== 33'h0_60AA_A000 || obs_q[3] !== 33'h0_78BB_BCCC) begin
        n_fail++;
        $display("FAIL flush_data: got %h %h, required 060aaa000 078bbbccc", obs_q[2], obs_q[3]);
      end
      n_checks++;
      if (stall_q[1] != 1 || stall_q[2] != 0) begin
        n_fail++;
        $display("FAIL flush_ready_low: got %0d %0d cycles, required 1 0", stall_q[1], stall_q[2]);
      end
    end
  endtask

  task automatic test_trunc;
    bit ok;
    logic [32:0] w;
    obs_q.delete();
    f_chan.delete();
    f_data.delete();
    for (int i = 0; i < 20; i++) begin
      f_chan.push_back(2'd1);
      f_data.push_back(12'(i * 7 + 1));
    end
    send_frame(32'h7777_0000);
    drain(ok);
    n_checks++;
    if (!ok || drv_timeout || n_acc != 20) begin
      n_fail++;
      $display("FAIL trunc_accept: got %0d samples accepted ok=%b, required 20", n_acc, ok);
    end
    n_checks++;
    if (obs_q.size() != 7) begin
      n_fail++;
      $display("FAIL trunc_words: got %0d words, required 7", obs_q.size());
    end else begin
      w = obs_q[6];
      n_checks++;
      if (w[32] !== 1'b1 || w[29] !== 1'b1 || w[25:16] !== 10'd4) begin
        n_fail++;
        $display("FAIL trunc_trailer: got last=%b trunc=%b wcnt=%0d, required 1 1 4", w[32], w[29], w[25:16]);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int n;
    bp_mode = 1;
    for (int f = 0; f < 200; f++) begin
      f_chan.delete();
      f_data.delete();
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        f_chan.push_back(2'($urandom_range(0, 1)));
        f_data.push_back(12'($urandom));
      end
      send_frame($urandom);
      drain(ok);
      n_checks++;
      if (!ok || drv_timeout) begin
        n_fail++;
        $display("FAIL bp_frame_timeout: frame %0d ok=%b drv_timeout=%b, required completion", f, ok, drv_timeout);
        break;
      end
    end
    bp_mode = 0;
  endtask

  task automatic test_drop_reset;
    bit ok;
    bp_mode = 2;
    drop_pulses = 0;
    exp_q.push_back({1'b0, 2'b10, 14'h0, 16'(evt_model)});
    exp_q.push_back({1'b0, 32'hD00D_F00D});
    @(negedge clk);
    trig_in = 1'b1;
    ts_in   = 32'hD00D_F00D;
    @(negedge clk);
    trig_in = 1'b0;
    repeat (4) @(negedge clk);
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    bp_mode = 0;
    repeat (4) @(negedge clk);
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (drop_pulses != 2 || drop_cnt !== 16'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_count: got pulses=%0d drop_cnt=%0d busy=%b, required 2 2 1", drop_pulses, drop_cnt, busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drop_headers: got %0d headers pending, required 0", exp_q.size());
    end
    bus.s_valid = 1'b1;
    bus.s_chan  = 2'd0;
    bus.s_data  = 12'h5A5;
    bus.s_last  = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.m_valid, bus.m_last, bus.m_data, busy, trig_drop, drop_cnt, bus.s_ready} !== 52'h0) begin
      n_fail++;
      $display("FAIL midframe_reset: got v=%b l=%b d=%h busy=%b drop=%b cnt=%h rdy=%b, required all 0",
               bus.m_valid, bus.m_last, bus.m_data, busy, trig_drop, drop_cnt, bus.s_ready);
    end
    exp_q.delete();
    evt_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    f_chan = '{2'd0, 2'd0};
    f_data = '{12'h123, 12'h456};
    send_frame(32'h0BAD_BEEF);
    drain(ok);
    n_checks++;
    if (!ok || drv_timeout || obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL after_reset_frame: got %0d words ok=%b, required 4", obs_q.size(), ok);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_chan  = 2'd0;
    bus.s_data  = 12'h0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_single_tail();
    test_flush();
    test_trunc();
    test_backpressure();
    test_drop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
